// File: rtl/px_mem_pkg.sv
// Shared constants and types for the pixel-memory server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package px_mem_pkg;

  // Pixel word width, fixed by the CCM datapath.
  localparam int PX_W           = 16;
  // Default SRAM depth (log2 of words) and address-port width.
  localparam int DEF_DEPTH_LOG2 = 16;
  localparam int DEF_ADDR_W     = 20;

  // Arbiter side, also used as the encoding of the last-served register.
  typedef enum logic {
    SIDE_RD = 1'b0,
    SIDE_WR = 1'b1
  } side_e;

  // Round-robin pick when both sides are eligible: the side not served last.
  function automatic side_e rr_pick(input side_e last_served);
    return (last_served == SIDE_WR) ? SIDE_RD : SIDE_WR;
  endfunction

endpackage

// File: rtl/px_mem_sram.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x DW, read-first, registered read.
// Latency: read data valid the cycle after en_i; write lands at the enabling edge.
// Backpressure: none; one access per cycle whenever en_i is high.
module px_mem_sram
  import px_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DW         = PX_W
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DW-1:0]         wdata_i,
  output logic [DW-1:0]         rdata_o
);

  // Storage is deliberately not reset so contents survive a logic reset.
  logic [DW-1:0] mem_q [2**DEPTH_LOG2];
  logic [DW-1:0] rdata_q;

  // Read-first port: the read register always sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/px_mem_server.sv
// Pixel-memory server: arbitrates CCM reads and loader writes onto one SRAM port.
// Latency: write commits in the grant cycle; read data + VLD two cycles after GRANT.
// Backpressure: requesters hold REQ until a one-cycle GRANT; round-robin under contention.
module px_mem_server
  import px_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  // Must be >= DEPTH_LOG2; bits above DEPTH_LOG2 flag an out-of-range access.
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxMem_RD_REQ,
  input  logic [ADDR_W-1:0] pxMem_RD_Addr,
  output logic              pxMem_RD_GRANT,
  output logic              pxMem_RD_VLD,
  output logic [PX_W-1:0]   pxMem_out,
  input  logic              pxMem_WR_REQ,
  input  logic [ADDR_W-1:0] pxMem_WR_Addr,
  input  logic [PX_W-1:0]   pxMem_WR_Data,
  output logic              pxMem_WR_GRANT,
  output logic              addr_err,
  input  logic              err_clr
);

  // Arbiter state.
  side_e last_served_q, last_served_d;
  logic  rd_win, wr_win;

  // Range check results.
  logic rd_oor, wr_oor;

  // SRAM port.
  logic                  sram_en, sram_we;
  logic [DEPTH_LOG2-1:0] sram_addr;
  logic [PX_W-1:0]       sram_rdata;

  // Read pipeline: stage 1 follows the SRAM read register, stage 2 is the output.
  logic            rd_v1_q, rd_v1_d;
  logic            rd_oor1_q, rd_oor1_d;
  logic            rd_v2_q, rd_v2_d;
  logic [PX_W-1:0] out_q, out_d;

  // Sticky error flag.
  logic addr_err_q, addr_err_d;
  logic err_set;

  // Any nonzero bit above the SRAM index marks the access out of range.
  if (ADDR_W > DEPTH_LOG2) begin : g_range
    assign rd_oor = |pxMem_RD_Addr[ADDR_W-1:DEPTH_LOG2];
    assign wr_oor = |pxMem_WR_Addr[ADDR_W-1:DEPTH_LOG2];
  end else begin : g_no_range
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;
  end

  // Arbiter: single eligible side wins outright, contention goes round-robin.
  // Grants are suppressed while reset is asserted so every output reads 0.
  always_comb begin
    rd_win        = 1'b0;
    wr_win        = 1'b0;
    last_served_d = last_served_q;
    if (rst_n) begin
      if (pxMem_RD_REQ && pxMem_WR_REQ) begin
        if (rr_pick(last_served_q) == SIDE_RD) begin
          rd_win = 1'b1;
        end else begin
          wr_win = 1'b1;
        end
      end else if (pxMem_RD_REQ) begin
        rd_win = 1'b1;
      end else if (pxMem_WR_REQ) begin
        wr_win = 1'b1;
      end
    end
    if (rd_win) begin
      last_served_d = SIDE_RD;
    end else if (wr_win) begin
      last_served_d = SIDE_WR;
    end
  end

  assign pxMem_RD_GRANT = rd_win;
  assign pxMem_WR_GRANT = wr_win;

  // SRAM port mux: out-of-range accesses are granted but never touch the array.
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = pxMem_RD_Addr[DEPTH_LOG2-1:0];
    if (wr_win) begin
      sram_addr = pxMem_WR_Addr[DEPTH_LOG2-1:0];
      sram_en   = !wr_oor;
      sram_we   = !wr_oor;
    end else if (rd_win) begin
      sram_en   = !rd_oor;
    end
  end

  px_mem_sram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DW         (PX_W)
  ) u_sram (
    .clk     (clk),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (pxMem_WR_Data),
    .rdata_o (sram_rdata)
  );

  // Pipeline and error next-state; out-of-range reads return zero, output holds otherwise.
  always_comb begin
    rd_v1_d   = rd_win;
    rd_oor1_d = rd_win & rd_oor;
    rd_v2_d   = rd_v1_q;
    out_d     = out_q;
    if (rd_v1_q) begin
      out_d = rd_oor1_q ? '0 : sram_rdata;
    end
    err_set    = (rd_win & rd_oor) | (wr_win & wr_oor);
    addr_err_d = addr_err_q;
    if (err_set) begin
      addr_err_d = 1'b1;
    end else if (err_clr) begin
      addr_err_d = 1'b0;
    end
  end

  // State registers; reset drops in-flight reads but leaves the SRAM untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served_q <= SIDE_WR;
      rd_v1_q       <= 1'b0;
      rd_oor1_q     <= 1'b0;
      rd_v2_q       <= 1'b0;
      out_q         <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      last_served_q <= last_served_d;
      rd_v1_q       <= rd_v1_d;
      rd_oor1_q     <= rd_oor1_d;
      rd_v2_q       <= rd_v2_d;
      out_q         <= out_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign pxMem_RD_VLD = rd_v2_q;
  assign pxMem_out    = out_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_px_mem_server.sv
// Directed self-checking bench for px_mem_server.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-derived from the documented behaviour.
module tb_px_mem_server;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic [19:0] rd_addr;
  logic        rd_grant;
  logic        rd_vld;
  logic [15:0] px_out;
  logic        wr_req;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_grant;
  logic        addr_err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  px_mem_server #(
    .DEPTH_LOG2 (16),
    .ADDR_W     (20)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pxMem_RD_REQ   (rd_req),
    .pxMem_RD_Addr  (rd_addr),
    .pxMem_RD_GRANT (rd_grant),
    .pxMem_RD_VLD   (rd_vld),
    .pxMem_out      (px_out),
    .pxMem_WR_REQ   (wr_req),
    .pxMem_WR_Addr  (wr_addr),
    .pxMem_WR_Data  (wr_data),
    .pxMem_WR_GRANT (wr_grant),
    .addr_err       (addr_err),
    .err_clr        (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point in the middle of the current cycle.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [15:0] tbl [4];

  initial begin
    tbl[0] = 16'h1111;
    tbl[1] = 16'h2222;
    tbl[2] = 16'h3333;
    tbl[3] = 16'h4444;

    rst_n   = 1'b0;
    rd_req  = 1'b0;
    rd_addr = '0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    err_clr = 1'b0;

    // Reset state, with a read request already pending: nothing may be granted.
    tick();
    rd_req = 1'b1;
    sample();
    chk("rst_rd_grant", {31'd0, rd_grant}, 32'd0);
    chk("rst_wr_grant", {31'd0, wr_grant}, 32'd0);
    chk("rst_vld",      {31'd0, rd_vld},   32'd0);
    chk("rst_out",      {16'd0, px_out},   32'd0);
    chk("rst_err",      {31'd0, addr_err}, 32'd0);
    tick();
    rd_req = 1'b0;
    rst_n  = 1'b1;

    // Write A5A5 to 0x10 at N, read it at N+1, data at N+3.
    wr_req = 1'b1; wr_addr = 20'h00010; wr_data = 16'hA5A5;
    sample();
    chk("t1_wr_grant", {31'd0, wr_grant}, 32'd1);
    chk("t1_rd_grant0", {31'd0, rd_grant}, 32'd0);
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 20'h00010;
    sample();
    chk("t1_rd_grant", {31'd0, rd_grant}, 32'd1);
    tick();
    rd_req = 1'b0;
    sample();
    chk("t1_vld_n2", {31'd0, rd_vld}, 32'd0);
    tick();
    sample();
    chk("t1_vld_n3", {31'd0, rd_vld}, 32'd1);
    chk("t1_data",   {16'd0, px_out}, 32'h0000A5A5);
    tick();
    sample();
    chk("t1_vld_n4",  {31'd0, rd_vld}, 32'd0);
    chk("t1_hold",    {16'd0, px_out}, 32'h0000A5A5);

    // Contention from reset: R,W,R,W... starting with READ.
    do_reset();
    rd_req = 1'b1; rd_addr = 20'h00010;
    wr_req = 1'b1; wr_addr = 20'h00020; wr_data = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      sample();
      chk($sformatf("t2_rd_grant_%0d", k), {31'd0, rd_grant}, {31'd0, (k < 8) && (k % 2 == 0)});
      chk($sformatf("t2_wr_grant_%0d", k), {31'd0, wr_grant}, {31'd0, (k < 8) && (k % 2 == 1)});
      chk($sformatf("t2_vld_%0d", k), {31'd0, rd_vld}, {31'd0, (k >= 2) && (k <= 8) && (k % 2 == 0)});
      if ((k >= 2) && (k <= 8) && (k % 2 == 0)) begin
        chk($sformatf("t2_data_%0d", k), {16'd0, px_out}, 32'h0000A5A5);
      end
      tick();
    end

    // Four back-to-back writes then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 20'(i); wr_data = tbl[i];
      sample();
      chk($sformatf("t3_wr_grant_%0d", i), {31'd0, wr_grant}, 32'd1);
      tick();
    end
    wr_req = 1'b0;
    for (int j = 0; j < 7; j++) begin
      rd_req  = (j < 4);
      rd_addr = 20'(j);
      sample();
      chk($sformatf("t3_rd_grant_%0d", j), {31'd0, rd_grant}, {31'd0, j < 4});
      chk($sformatf("t3_vld_%0d", j), {31'd0, rd_vld}, {31'd0, (j >= 2) && (j <= 5)});
      if ((j >= 2) && (j <= 5)) begin
        chk($sformatf("t3_data_%0d", j), {16'd0, px_out}, {16'd0, tbl[j-2]});
      end
      tick();
    end
    rd_req = 1'b0;

    // Out-of-range read: granted, returns zero, sets the sticky error.
    rd_req = 1'b1; rd_addr = 20'h10000;
    sample();
    chk("t4_grant",     {31'd0, rd_grant}, 32'd1);
    chk("t4_err_pre",   {31'd0, addr_err}, 32'd0);
    tick();
    rd_req = 1'b0;
    sample();
    chk("t4_err_set",   {31'd0, addr_err}, 32'd1);
    tick();
    err_clr = 1'b1;
    sample();
    chk("t4_vld",       {31'd0, rd_vld},   32'd1);
    chk("t4_zero",      {16'd0, px_out},   32'd0);
    tick();
    err_clr = 1'b0;
    sample();
    chk("t4_err_clr",   {31'd0, addr_err}, 32'd0);
    tick();
    err_clr = 1'b1; rd_req = 1'b1; rd_addr = 20'h10000;
    tick();
    err_clr = 1'b0; rd_req = 1'b0;
    sample();
    chk("t4_set_wins",  {31'd0, addr_err}, 32'd1);
    tick();
    tick();

    // Out-of-range write is discarded; the aliased in-range word keeps its value.
    wr_req = 1'b1; wr_addr = 20'h0FFFF; wr_data = 16'hBEEF;
    tick();
    wr_req = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    wr_req = 1'b1; wr_addr = 20'h1FFFF; wr_data = 16'hDEAD;
    sample();
    chk("t6_wr_grant",  {31'd0, wr_grant}, 32'd1);
    chk("t6_err_pre",   {31'd0, addr_err}, 32'd0);
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 20'h0FFFF;
    sample();
    chk("t6_rd_grant",  {31'd0, rd_grant}, 32'd1);
    chk("t6_err",       {31'd0, addr_err}, 32'd1);
    tick();
    rd_req = 1'b0;
    tick();
    sample();
    chk("t6_vld",       {31'd0, rd_vld},   32'd1);
    chk("t6_data",      {16'd0, px_out},   32'h0000BEEF);

    // Reset one cycle after a read grant: the read never completes.
    tick();
    rd_req = 1'b1; rd_addr = 20'h00001;
    sample();
    chk("t5_grant",     {31'd0, rd_grant}, 32'd1);
    tick();
    rd_req = 1'b0; rst_n = 1'b0;
    sample();
    chk("t5_rst_vld",   {31'd0, rd_vld},   32'd0);
    chk("t5_rst_out",   {16'd0, px_out},   32'd0);
    chk("t5_rst_err",   {31'd0, addr_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk($sformatf("t5_no_vld_%0d", c), {31'd0, rd_vld}, 32'd0);
      chk($sformatf("t5_out_%0d", c),    {16'd0, px_out}, 32'd0);
      tick();
    end
    // Word written before reset is still there.
    rd_req = 1'b1; rd_addr = 20'h00020;
    tick();
    rd_req = 1'b0;
    tick();
    sample();
    chk("t5_keep_vld",  {31'd0, rd_vld},   32'd1);
    chk("t5_keep_data", {16'd0, px_out},   32'h00001234);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/px_mem_server.md
# px_mem_server

Pixel-memory responder that serves the CCM's pixel read port (pxMem_RD_REQ/GRANT/Addr/VLD/data) out of a single-port on-chip SRAM. It also accepts writes from the feature-map loader on a second request/grant port and arbitrates the two onto the one SRAM port. It sits between the feature-map loader and the convolution cluster, and owns all pixel-buffer storage.

## Interface
- DEPTH_LOG2, 16: SRAM depth is 2^DEPTH_LOG2 16-bit words.
- ADDR_W, 20: width of both address ports. Must be ≥ DEPTH_LOG2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pxMem_RD_REQ  in  1  read request from the CCM. Held until granted.
- pxMem_RD_Addr  in  ADDR_W  read word address. Stable while REQ is high.
- pxMem_RD_GRANT  out  1  one-cycle pulse: read accepted this cycle.
- pxMem_RD_VLD  out  1  one-cycle pulse: pxMem_out carries read data.
- pxMem_out  out  16  read data.
- pxMem_WR_REQ  in  1  write request from the loader. Held until granted.
- pxMem_WR_Addr  in  ADDR_W  write word address.
- pxMem_WR_Data  in  16  write data.
- pxMem_WR_GRANT  out  1  one-cycle pulse: write committed this cycle.
- addr_err  out  1  sticky flag: an access targeted an address ≥ 2^DEPTH_LOG2.
- err_clr  in  1  synchronous clear of addr_err.

## Operation
- Per cycle the arbiter picks at most one requester. Only a request that is high and not already granted this cycle is eligible.
- Both requesters eligible: round-robin on a 1-bit last_served register. The side not served last wins.
- Only one side eligible: that side wins and last_served updates to it.
- Reset value of last_served = WRITE, so the first contended cycle goes to READ.
- Granted read:
  - GRANT=1 in the grant cycle and SRAM read enable is asserted with Addr[DEPTH_LOG2-1:0].
  - A 2-stage valid/range pipeline (rd_v1, rd_v2) tracks the access.
- Granted write: WR_GRANT=1 and the SRAM write occurs in the same cycle.
- Requester rule: after seeing GRANT, the requester either drops REQ or presents the next address in the following cycle. Back-to-back grants to one side are legal when the other side is idle.
- Out-of-range access (upper address bits nonzero):
  - The access is still granted.
  - A write is discarded (no SRAM write).
  - A read returns pxMem_out=16'h0000 with VLD=1.
  - addr_err sets on the grant cycle.
  - If err_clr and a new error occur in the same cycle, set wins.
- Read-after-write to the same address in consecutive grants returns the new data. The SRAM is read-first, but the write precedes the read by ≥1 cycle, so no bypass is needed.
- Reset:
  - All outputs go to 0: GRANT, WR_GRANT, VLD, pxMem_out, addr_err.
  - The pipeline valids clear. In-flight reads are dropped and never produce VLD.
  - SRAM contents are not cleared.

## Timing
- Read latency: GRANT at cycle N gives VLD and data at cycle N+2. Stage 1 is the registered SRAM read, stage 2 is the output register.
- Throughput: one access per cycle total. Under continuous contention each side gets 1 access per 2 cycles.
- VLD is never held for more than 1 cycle per grant. Data order equals grant order.
- GRANT/WR_GRANT are registered-free combinational decodes of the arbiter state plus REQ. They are never both high in one cycle.
- pxMem_out holds its last value when VLD=0.

## Structure
- px_mem_pkg holds:
  - constants PX_W=16 and the default DEPTH_LOG2/ADDR_W;
  - the arbiter side enum {SIDE_RD, SIDE_WR}.
- Sub-module px_mem_sram: single-port synchronous RAM, registered read, read-first, 2^DEPTH_LOG2 × 16. Kept separate so it can be swapped for a foundry macro.
- Top level contains the arbiter, range check, read pipeline and error flag.

## Test plan
- Write 16'hA5A5 to addr 0x00010, then read 0x00010 → WR_GRANT at N. RD GRANT at N+1, VLD with 16'hA5A5 at N+3.
- RD and WR requests both held for 8 cycles from reset → grants alternate R,W,R,W…, starting with READ. 4 VLD pulses, each 2 cycles after its RD grant.
- Four back-to-back reads 0x0,0x1,0x2,0x3 with no writer → GRANT on 4 consecutive cycles. Data returned in order on 4 consecutive VLD cycles.
- Read addr 0x10000 with DEPTH_LOG2=16 → GRANT, VLD with 16'h0000, addr_err=1. err_clr pulse → addr_err=0. err_clr in the same cycle as a new error → addr_err stays 1.
- Assert rst_n=0 one cycle after an RD GRANT → no VLD after reset release, all outputs 0. A later read of a previously written address returns the pre-reset data.
- Write to out-of-range 0x1FFFF, then read 0x0FFFF → the SRAM word is unchanged (previous value returned) and addr_err=1.
